// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_res_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_t;

    // Bit order of the result is {less, eq, greater}.
    function automatic logic [2:0] cmp_to_onehot(input cmp_res_t r);
        logic [2:0] oh;
        case (r)
            CMP_LT:  oh = 3'b100;
            CMP_GT:  oh = 3'b001;
            default: oh = 3'b010;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// Single-digit unsigned magnitude compare: i_a vs i_b -> LT/EQ/GT.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; no handshake.
// Ports: i_a, i_b - DIGIT_W-bit digits; o_res - comparison verdict.
module serial_cmp_digit
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    output cmp_res_t           o_res
);

    always_comb begin
        o_res = CMP_EQ;
        if (i_a < i_b) begin
            o_res = CMP_LT;
        end else if (i_a > i_b) begin
            o_res = CMP_GT;
        end
    end

endmodule

// File: rtl/serial_comparator_digit.sv
// Digit-serial magnitude comparator: one LT/EQ/GT verdict per in_last-framed frame.
// Latency: verdict is valid 1 cycle after the accepted in_last beat.
// Backpressure: in_ready = !res_valid | res_ready; a held verdict stalls input.
// Ports: clk/rst_n (sync, active low); in_valid/in_ready/in_last/a/b digit stream;
//        res_valid/res_ready result handshake; res_less/eq/greater, res_len, res_ovf.
// Build option: define SERIAL_CMP_SIGNED_EN for two's-complement operands.
module serial_comparator_digit
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W    = 4,
    parameter int MSB_FIRST  = 1,
    parameter int MAX_DIGITS = 16,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_less,
    output logic               res_eq,
    output logic               res_greater,
    output logic [CW-1:0]      res_len,
    output logic               res_ovf
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

    frame_state_t r_state;
    frame_state_t w_state_nxt;
    cmp_res_t     r_run;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_res_valid;
    logic [2:0]    r_res_oh;
    logic [CW-1:0] r_res_len;
    logic          r_res_ovf;

    logic               w_accept;
    logic               w_first;
    logic [DIGIT_W-1:0] w_a;
    logic [DIGIT_W-1:0] w_b;
    cmp_res_t           w_d;
    cmp_res_t           w_prev;
    cmp_res_t           w_next;
    logic [CW-1:0]      w_cnt_next;
    logic               w_ovf_next;

    assign in_ready = !r_res_valid || res_ready;
    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_state == ST_IDLE);

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    logic w_sign_dig;
    assign w_sign_dig = (MSB_FIRST != 0) ? w_first : in_last;

    always_comb begin
        w_a = a;
        w_b = b;
        w_a[DIGIT_W-1] = a[DIGIT_W-1] ^ w_sign_dig;
        w_b[DIGIT_W-1] = b[DIGIT_W-1] ^ w_sign_dig;
    end
`else
    assign w_a = a;
    assign w_b = b;
`endif

    serial_cmp_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_res (w_d)
    );

    // MSB-first: earliest unequal digit decides. LSB-first: latest unequal digit decides.
    always_comb begin
        w_prev = w_first ? CMP_EQ : r_run;
        w_next = w_prev;
        if (MSB_FIRST != 0) begin
            w_next = (w_prev != CMP_EQ) ? w_prev : w_d;
        end else begin
            w_next = (w_d != CMP_EQ) ? w_d : w_prev;
        end
    end

    // Count saturates at MAX_DIGITS; the digit that would pass it raises overflow.
    always_comb begin
        w_cnt_next = (r_cnt == MAX_CNT) ? MAX_CNT : r_cnt + CW'(1);
        w_ovf_next = r_ovf || (r_cnt == MAX_CNT);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = in_last ? ST_IDLE : ST_IN_FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame accumulators; cleared after a last beat so the next frame starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= CMP_EQ;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_run <= CMP_EQ;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_run <= w_next;
                r_cnt <= w_cnt_next;
                r_ovf <= w_ovf_next;
            end
        end
    end

    // Result fields hold after the consumer takes them; only valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_oh    <= 3'b000;
            r_res_len   <= '0;
            r_res_ovf   <= 1'b0;
        end else if (w_accept && in_last) begin
            r_res_valid <= 1'b1;
            r_res_oh    <= cmp_to_onehot(w_next);
            r_res_len   <= w_cnt_next;
            r_res_ovf   <= w_ovf_next;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid   = r_res_valid;
    assign res_less    = r_res_oh[2];
    assign res_eq      = r_res_oh[1];
    assign res_greater = r_res_oh[0];
    assign res_len     = r_res_len;
    assign res_ovf     = r_res_ovf;

endmodule

// File: tb/tb_serial_comparator_digit.sv
module tb_serial_comparator_digit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_last;
    logic [3:0] a;
    logic [3:0] b;
    logic       res_ready;

    // u0: MSB-first, MAX 16
    logic       rdy0, val0, lt0, eq0, gt0, ovf0;
    logic [4:0] len0;
    // u1: LSB-first, MAX 16
    logic       rdy1, val1, lt1, eq1, gt1, ovf1;
    logic [4:0] len1;
    // u2: MSB-first, MAX 4
    logic       rdy2, val2, lt2, eq2, gt2, ovf2;
    logic [2:0] len2;

    int checks = 0;
    int errors = 0;

    serial_comparator_digit #(.DIGIT_W(4), .MSB_FIRST(1), .MAX_DIGITS(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
        .a(a), .b(b), .res_valid(val0), .res_ready(res_ready), .res_less(lt0), .res_eq(eq0),
        .res_greater(gt0), .res_len(len0), .res_ovf(ovf0));

    serial_comparator_digit #(.DIGIT_W(4), .MSB_FIRST(0), .MAX_DIGITS(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
        .a(a), .b(b), .res_valid(val1), .res_ready(res_ready), .res_less(lt1), .res_eq(eq1),
        .res_greater(gt1), .res_len(len1), .res_ovf(ovf1));

    serial_comparator_digit #(.DIGIT_W(4), .MSB_FIRST(1), .MAX_DIGITS(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
        .a(a), .b(b), .res_valid(val2), .res_ready(res_ready), .res_less(lt2), .res_eq(eq2),
        .res_greater(gt2), .res_len(len2), .res_ovf(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one digit pair for exactly one rising edge, then look 1 time unit later.
    task automatic drive_beat(input logic [3:0] da, input logic [3:0] db, input logic dl);
        @(negedge clk);
        in_valid = 1'b1;
        a        = da;
        b        = db;
        in_last  = dl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", val0); end
        checks++;
        if ({lt0, eq0, gt0} !== 3'b000) begin errors++; $display("FAIL reset_verdict got %b want 000", {lt0, eq0, gt0}); end
        checks++;
        if (len0 !== 5'd0 || ovf0 !== 1'b0) begin errors++; $display("FAIL reset_len_ovf got %0d/%b want 0/0", len0, ovf0); end
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_msb_first();
        // 0x3A5 vs 0x3B0, most significant digit first
        drive_beat(4'h3, 4'h3, 1'b0);
        checks++;
        if (val0 !== 1'b0) begin errors++; $display("FAIL msb_midframe_valid got %b want 0", val0); end
        drive_beat(4'hA, 4'hB, 1'b0);
        drive_beat(4'h5, 4'h0, 1'b1);
        checks++;
        if (val0 !== 1'b1 || {lt0, eq0, gt0} !== 3'b100) begin
            errors++; $display("FAIL msb_verdict got v=%b lt/eq/gt=%b want v=1 100", val0, {lt0, eq0, gt0});
        end
        checks++;
        if (len0 !== 5'd3 || ovf0 !== 1'b0) begin errors++; $display("FAIL msb_len got %0d/%b want 3/0", len0, ovf0); end
        // LSB-first instance reads the same stream as 0x5A3 vs 0x0B3
        checks++;
        if ({lt1, eq1, gt1} !== 3'b001) begin errors++; $display("FAIL msb_stream_on_lsb got %b want 001", {lt1, eq1, gt1}); end
        idle_cycle();
        checks++;
        if (val0 !== 1'b0 || lt0 !== 1'b1 || len0 !== 5'd3) begin
            errors++; $display("FAIL msb_drain got v=%b lt=%b len=%0d want 0 1 3", val0, lt0, len0);
        end
    endtask

    task automatic test_lsb_first();
        // 0x3A5 vs 0x3B0, least significant digit first
        drive_beat(4'h5, 4'h0, 1'b0);
        drive_beat(4'hA, 4'hB, 1'b0);
        drive_beat(4'h3, 4'h3, 1'b1);
        checks++;
        if (val1 !== 1'b1 || {lt1, eq1, gt1} !== 3'b100 || len1 !== 5'd3) begin
            errors++; $display("FAIL lsb_verdict got v=%b %b len=%0d want 1 100 3", val1, {lt1, eq1, gt1}, len1);
        end
        // MSB-first instance reads 0x5A3 vs 0x0B3
        checks++;
        if ({lt0, eq0, gt0} !== 3'b001) begin errors++; $display("FAIL lsb_stream_on_msb got %b want 001", {lt0, eq0, gt0}); end
        idle_cycle();
    endtask

    task automatic test_single_digit_sign();
        logic [2:0] exp_oh;
`ifdef SERIAL_CMP_SIGNED_EN
        exp_oh = 3'b100;   // -8 < 1
`else
        exp_oh = 3'b001;   // 8 > 1
`endif
        drive_beat(4'h8, 4'h1, 1'b1);
        checks++;
        if (val0 !== 1'b1 || {lt0, eq0, gt0} !== exp_oh || len0 !== 5'd1) begin
            errors++; $display("FAIL single_msb got v=%b %b len=%0d want 1 %b 1", val0, {lt0, eq0, gt0}, len0, exp_oh);
        end
        checks++;
        if ({lt1, eq1, gt1} !== exp_oh || len1 !== 5'd1) begin
            errors++; $display("FAIL single_lsb got %b len=%0d want %b 1", {lt1, eq1, gt1}, len1, exp_oh);
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        drive_beat(4'h1, 4'h2, 1'b1);
        checks++;
        if (val0 !== 1'b1 || lt0 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL bp_hold got v=%b lt=%b rdy=%b want 1 1 0", val0, lt0, rdy0);
        end
        // offer a frame that would flip the verdict while stalled
        @(negedge clk);
        in_valid = 1'b1; a = 4'h9; b = 4'h0; in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (val0 !== 1'b1 || {lt0, eq0, gt0} !== 3'b100 || len0 !== 5'd1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL bp_stable got v=%b %b len=%0d rdy=%b want 1 100 1 0", val0, {lt0, eq0, gt0}, len0, rdy0);
        end
        // release: the held beat is taken in the same cycle the verdict is consumed
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (val0 !== 1'b1 || {lt0, eq0, gt0} !== 3'b001) begin
            errors++; $display("FAIL back_to_back got v=%b %b want 1 001", val0, {lt0, eq0, gt0});
        end
        idle_cycle();
        checks++;
        if (val0 !== 1'b0 || gt0 !== 1'b1) begin errors++; $display("FAIL bp_drain got v=%b gt=%b want 0 1", val0, gt0); end
    endtask

    task automatic test_reset_mid_frame();
        drive_beat(4'h5, 4'h3, 1'b0);
        drive_beat(4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (val0 !== 1'b0 || len0 !== 5'd0) begin errors++; $display("FAIL rst_mid_clear got v=%b len=%0d want 0 0", val0, len0); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_beat(4'h1, 4'h1, 1'b0);
        drive_beat(4'h1, 4'h1, 1'b1);
        checks++;
        if (val0 !== 1'b1 || {lt0, eq0, gt0} !== 3'b010 || len0 !== 5'd2) begin
            errors++; $display("FAIL rst_mid_frame got v=%b %b len=%0d want 1 010 2", val0, {lt0, eq0, gt0}, len0);
        end
        idle_cycle();
    endtask

    task automatic test_overflow();
        // exactly MAX_DIGITS digits on u2: no overflow
        for (int i = 0; i < 4; i++) drive_beat(4'h7, 4'h7, (i == 3));
        checks++;
        if (val2 !== 1'b1 || eq2 !== 1'b1 || len2 !== 3'd4 || ovf2 !== 1'b0) begin
            errors++; $display("FAIL ovf_exact got v=%b eq=%b len=%0d ovf=%b want 1 1 4 0", val2, eq2, len2, ovf2);
        end
        // one digit more than capacity
        for (int i = 0; i < 5; i++) drive_beat(4'h7, 4'h7, (i == 4));
        checks++;
        if (val2 !== 1'b1 || eq2 !== 1'b1 || len2 !== 3'd4 || ovf2 !== 1'b1) begin
            errors++; $display("FAIL ovf_over got v=%b eq=%b len=%0d ovf=%b want 1 1 4 1", val2, eq2, len2, ovf2);
        end
        checks++;
        if (len0 !== 5'd5 || ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_large_cap got len=%0d ovf=%b want 5 0", len0, ovf0); end
        idle_cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        a         = 4'h0;
        b         = 4'h0;
        res_ready = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_single_digit_sign();
        test_backpressure();
        test_reset_mid_frame();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
